// File: rtl/thread_sched_rr16.sv
// rtl/thread_sched_rr16.sv - 16-thread round-robin issue scheduler with per-thread grant quantum
// Optional high-priority mask selected by THREAD_SCHED_HIPRIO_EN.
module thread_sched_rr16 #(
    parameter int QUANTUM = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] ready_i,
    input  logic        ack_i,
    input  logic        flush_i,
`ifdef THREAD_SCHED_HIPRIO_EN
    input  logic [15:0] hp_mask_i,
`endif
    output logic [3:0]  sel_o_16,
    output logic        sel_valid_o,
    output logic        state_o
);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_GRANT = 1'b1
    } state_t;

    localparam logic [3:0] QMAX = 4'(QUANTUM - 1);

    state_t      state_q;
    logic [3:0]  sel_q;
    logic [3:0]  ptr_q;
    logic [3:0]  cnt_q;

    logic        pick_d;
    logic        regrant_d;
    logic [15:0] search_mask_d;
    logic [4:0]  winner_d;

    // Scan base+1 .. base+16 (base itself last); descending loop keeps the nearest hit.
    function automatic logic [4:0] rr_search(input logic [15:0] mask, input logic [3:0] base);
        logic [4:0] r;
        logic [3:0] idx;
        r = 5'd0;
        for (int i = 16; i >= 1; i--) begin
            idx = base + 4'(i);
            if (mask[idx]) begin
                r = {1'b1, idx};
            end
        end
        return r;
    endfunction

    always_comb begin
        pick_d = (state_q == S_IDLE) || ack_i;
`ifdef THREAD_SCHED_HIPRIO_EN
        search_mask_d = ((ready_i & hp_mask_i) != 16'h0) ? (ready_i & hp_mask_i) : ready_i;
        regrant_d = (state_q == S_GRANT) && ack_i && (cnt_q < QMAX) && ready_i[ptr_q]
                    && !(((ready_i & hp_mask_i) != 16'h0) && !hp_mask_i[ptr_q]);
`else
        search_mask_d = ready_i;
        regrant_d = (state_q == S_GRANT) && ack_i && (cnt_q < QMAX) && ready_i[ptr_q];
`endif
        winner_d = rr_search(search_mask_d, ptr_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            sel_q   <= 4'h0;
            ptr_q   <= 4'hF;
            cnt_q   <= 4'h0;
        end else if (flush_i) begin
            state_q <= S_IDLE;
            ptr_q   <= 4'hF;
            cnt_q   <= 4'h0;
        end else if (pick_d) begin
            if (regrant_d) begin
                state_q <= S_GRANT;
                sel_q   <= ptr_q;
                cnt_q   <= cnt_q + 4'd1;
            end else if (winner_d[4]) begin
                state_q <= S_GRANT;
                sel_q   <= winner_d[3:0];
                ptr_q   <= winner_d[3:0];
                cnt_q   <= 4'h0;
            end else begin
                state_q <= S_IDLE;
            end
        end
    end

    assign sel_o_16    = sel_q;
    assign sel_valid_o = (state_q == S_GRANT);
    assign state_o     = state_q;

endmodule

// File: doc/thread_sched_rr16.md
THREAD_SCHED_RR16 -- requirements
Module: thread_sched_rr16

Interface
REQ-001 Parameter QUANTUM, default 4, the maximum number of consecutive grants to one thread before rotation; legal range 1..15.
REQ-002 clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 ready_i  input  16  per-thread ready mask; bit k set means thread k can issue.
REQ-005 ack_i  input  1  downstream accepts the current grant this cycle.
REQ-006 flush_i  input  1  synchronous flush of the grant and rotation state.
REQ-007 sel_o_16  output  4  registered index of the granted thread; drives the 16:1 32-bit operand mux select.
REQ-008 sel_valid_o  output  1  registered; high means sel_o_16 holds a live grant.
REQ-009 state_o  output  1  current FSM state: 0 = IDLE, 1 = GRANT.

Function
REQ-010 The FSM SHALL have exactly two states: IDLE (sel_valid_o=0) and GRANT (sel_valid_o=1).
REQ-011 Internal state SHALL be a 4-bit last-grant pointer ptr and a 4-bit consecutive-grant counter cnt.
REQ-012 A pick SHALL occur in any cycle where state is IDLE, or state is GRANT and ack_i=1.
REQ-013 Pick rule when cnt < QUANTUM-1, ready_i[ptr]=1 and state is GRANT with ack_i=1: re-grant ptr and increment cnt.
REQ-014 Otherwise, pick rule: grant the first set bit of ready_i searching ptr+1, ptr+2, ... modulo 16 and ending with ptr; set cnt=0, even if the winner equals ptr.
REQ-015 If a pick finds ready_i=0, the next state SHALL be IDLE, sel_o_16 SHALL hold its last value, and ptr and cnt SHALL be unchanged.
REQ-016 A successful pick SHALL load sel_o_16 and ptr with the winner and set the next state to GRANT; the result is visible on the next clock edge, so latency is 1 cycle from ready to grant.
REQ-017 In GRANT with ack_i=0, sel_o_16, sel_valid_o, ptr and cnt SHALL hold, even if ready_i of the granted thread deasserts.
REQ-018 In GRANT with ack_i=1 and a ready thread available, sel_valid_o SHALL stay 1 with the new index next cycle, giving one grant per cycle at full throughput.
REQ-019 ack_i SHALL be ignored while in IDLE.
REQ-020 flush_i=1 SHALL force IDLE, ptr=4'hF and cnt=0 on the next edge, overriding any pick or ack in the same cycle; sel_o_16 SHALL hold.
REQ-021 The pointer search SHALL wrap from 15 to 0 with no skipped or duplicated index.
REQ-022 With QUANTUM=1, the block SHALL behave as pure round-robin.

Reset
REQ-023 While rst_n=0, the block SHALL asynchronously set state=IDLE, sel_valid_o=0, sel_o_16=4'h0, ptr=4'hF and cnt=0.
REQ-024 The first pick after reset release SHALL search from thread 0.
REQ-025 Reset asserted mid-GRANT SHALL drop sel_valid_o immediately without waiting for a clock edge.

Configuration
REQ-026 Macro THREAD_SCHED_HIPRIO_EN, when defined, SHALL add input hp_mask_i (16 bits).
REQ-027 With THREAD_SCHED_HIPRIO_EN defined, the REQ-014 search SHALL run first over ready_i & hp_mask_i and fall back to ready_i only when that set is empty.
REQ-028 With THREAD_SCHED_HIPRIO_EN defined, the REQ-013 quantum re-grant SHALL be suppressed whenever (ready_i & hp_mask_i) is non-zero and excludes ptr.
REQ-029 Without THREAD_SCHED_HIPRIO_EN, the hp_mask_i port SHALL be absent and the behaviour SHALL be exactly REQ-010..REQ-022.

Verification
REQ-030 Reset release, ready_i=16'h0011, ack_i held 1, QUANTUM=1 -> grants 0,4,0,4,... one per cycle starting the cycle after ready.
REQ-031 QUANTUM=4, ready_i=16'hFFFF, ack_i=1 -> grants 0,0,0,0,1,1,1,1,2,...; after 15 the sequence wraps to 0.
REQ-032 Grant to thread 3, ack_i=0 for 5 cycles while ready_i[3] drops -> sel_o_16=3 and sel_valid_o=1 stable all 5 cycles.
REQ-033 ready_i=0 in GRANT with ack_i=1 -> IDLE next cycle, sel_o_16 held; ready_i=16'h8000 later -> grant 15 one cycle after.
REQ-034 flush_i and ack_i both 1 with ready_i=16'hFFFF -> IDLE next cycle, then grant 0; rst_n pulsed low mid-grant -> sel_valid_o=0 asynchronously.
REQ-035 THREAD_SCHED_HIPRIO_EN defined, ready_i=16'hFFFF, hp_mask_i=16'h0100, QUANTUM=4 -> thread 8 granted repeatedly with cnt reset; clearing hp_mask_i resumes rotation from 9.
